// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding, opcode constants, reset PC and
// the next-PC address helpers.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [25:0] index);
    return {pc_plus4[31:28], index, 2'b00};
  endfunction

  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection for the held instruction; a jump outranks a taken branch.
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instr,
  input  logic        Jump,
  input  logic        Branch,
  input  logic        Zero,
  output logic [31:0] next_pc
);

  // Opcode bits are decoded elsewhere; only the address fields matter here.
  logic unused_op_s;
  assign unused_op_s = &{1'b0, instr[31:26]};

  // Priority select between jump target, branch target and fall-through.
  always_comb begin
    next_pc = pc_plus4;
    if (Jump) begin
      next_pc = jump_target(pc_plus4, instr[25:0]);
    end else if (Branch && Zero) begin
      next_pc = pc_plus4 + branch_offset(instr[15:0]);
    end else begin
      next_pc = pc_plus4;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: req/ack toward instruction memory, valid/ready
// toward decode, PC update on each accepted instruction.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             halt,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [31:0]      instr,
  output logic [5:0]       Op,
  output logic [31:0]      pc_plus4,
  input  logic             Jump,
  input  logic             Branch,
  input  logic             Zero,
  output logic [CNT_W-1:0] retired
);
  import cpu_pkg::*;

  fetch_state_t     state_r, state_s;
  logic [31:0]      pc_r;
  logic [31:0]      instr_r;
  logic [CNT_W-1:0] retired_r;
  logic [31:0]      next_pc_s;
  logic             accept_s;

  assign accept_s  = (state_r == HOLD) && instr_ready;
  assign imem_addr = pc_r;
  assign instr     = instr_r;
  assign Op        = instr_r[31:26];
  assign pc_plus4  = pc_r + 32'd4;
  assign retired   = retired_r;

  next_pc_calc u_next_pc (
    .pc_plus4 (pc_plus4),
    .instr    (instr_r),
    .Jump     (Jump),
    .Branch   (Branch),
    .Zero     (Zero),
    .next_pc  (next_pc_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; an outstanding fetch always completes, even under halt.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = halt ? IDLE : FETCH;
      FETCH:   state_s = imem_ack ? HOLD : FETCH;
      HOLD: begin
        if (instr_ready) begin
          state_s = halt ? IDLE : FETCH;
        end else begin
          state_s = HOLD;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register only.
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state_r)
      FETCH:   imem_req    = 1'b1;
      HOLD:    instr_valid = 1'b1;
      default: begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
      end
    endcase
  end

  // Datapath: capture on ack in FETCH only; PC and counter advance on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r      <= RESET_PC;
      instr_r   <= 32'h0000_0000;
      retired_r <= '0;
    end else begin
      if ((state_r == FETCH) && imem_ack) begin
        instr_r <= imem_rdata;
      end
      if (accept_s) begin
        pc_r      <= next_pc_s;
        retired_r <= retired_r + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; a second instance with a small
// counter and a top-of-memory reset PC covers the wrap-around corners.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        halt, imem_ack, instr_ready, Jump, Branch, Zero;
  logic [31:0] imem_rdata;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, instr, pc_plus4;
  logic [5:0]  Op;
  logic [31:0] retired;

  logic        b_halt, b_ack, b_ready, b_jump, b_branch, b_zero;
  logic [31:0] b_rdata;
  logic        b_req, b_valid;
  logic [31:0] b_addr, b_instr, b_pc_plus4;
  logic [5:0]  b_op;
  logic [1:0]  b_retired;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .halt(halt),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .Op(Op), .pc_plus4(pc_plus4),
    .Jump(Jump), .Branch(Branch), .Zero(Zero), .retired(retired)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .halt(b_halt),
    .imem_req(b_req), .imem_addr(b_addr), .imem_ack(b_ack),
    .imem_rdata(b_rdata), .instr_valid(b_valid), .instr_ready(b_ready),
    .instr(b_instr), .Op(b_op), .pc_plus4(b_pc_plus4),
    .Jump(b_jump), .Branch(b_branch), .Zero(b_zero), .retired(b_retired)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; halt = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
    instr_ready = 1'b0; Jump = 1'b0; Branch = 1'b0; Zero = 1'b0;
    b_halt = 1'b1; b_ack = 1'b0; b_rdata = 32'h0; b_ready = 1'b0;
    b_jump = 1'b0; b_branch = 1'b0; b_zero = 1'b0;
    #1;
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_retired", retired, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // R-type, memory acks in the first FETCH cycle
    halt = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0000_0020;
    tick();
    check("t1_req", {31'd0, imem_req}, 32'd1);
    check("t1_addr", imem_addr, 32'h0);
    check("t1_valid0", {31'd0, instr_valid}, 32'd0);
    tick();
    check("t1_valid", {31'd0, instr_valid}, 32'd1);
    check("t1_instr", instr, 32'h0000_0020);
    check("t1_op", {26'd0, Op}, 32'd0);
    check("t1_pcp4", pc_plus4, 32'h4);
    imem_ack = 1'b0; instr_ready = 1'b1;
    tick();
    check("t1_next_addr", imem_addr, 32'h4);
    check("t1_retired", retired, 32'd1);
    check("t1_req2", {31'd0, imem_req}, 32'd1);

    // Jump at pc 0x4
    instr_ready = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0800_0010;
    tick();
    check("t2_op", {26'd0, Op}, 32'd2);
    imem_ack = 1'b0; instr_ready = 1'b1; Jump = 1'b1;
    tick();
    check("t2_jump_addr", imem_addr, 32'h0000_0040);
    check("t2_retired", retired, 32'd2);

    // beq taken at 0x40
    Jump = 1'b0; instr_ready = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h1000_FFFF;
    tick();
    check("t3_op", {26'd0, Op}, 32'd4);
    check("t3_pcp4", pc_plus4, 32'h44);
    imem_ack = 1'b0; instr_ready = 1'b1; Branch = 1'b1; Zero = 1'b1;
    tick();
    check("t3_taken_addr", imem_addr, 32'h40);
    // beq not taken
    instr_ready = 1'b0; imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0; instr_ready = 1'b1; Branch = 1'b1; Zero = 1'b0;
    tick();
    check("t3_nottaken_addr", imem_addr, 32'h44);
    // jump and branch both asserted at 0x44
    instr_ready = 1'b0; imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0; instr_ready = 1'b1; Jump = 1'b1; Branch = 1'b1; Zero = 1'b1;
    tick();
    check("t3_jump_prio", imem_addr, 32'h0003_FFFC);
    check("t3_retired", retired, 32'd5);

    // slow memory, then slow decode with stray acks during HOLD
    Jump = 1'b0; Branch = 1'b0; Zero = 1'b0; instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_wait_req", {31'd0, imem_req}, 32'd1);
      check("t4_wait_addr", imem_addr, 32'h0003_FFFC);
    end
    imem_ack = 1'b1; imem_rdata = 32'hAC11_2233;
    tick();
    imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t4_hold_valid", {31'd0, instr_valid}, 32'd1);
      check("t4_hold_instr", instr, 32'hAC11_2233);
      check("t4_hold_retired", retired, 32'd5);
    end
    instr_ready = 1'b1;
    tick();
    imem_ack = 1'b0;
    check("t4_next_addr", imem_addr, 32'h0004_0000);
    check("t4_retired", retired, 32'd6);

    // halt during HOLD: instruction delivered, then park
    instr_ready = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h8C00_0000;
    tick();
    imem_ack = 1'b0; halt = 1'b1; instr_ready = 1'b1;
    tick();
    check("t5_req_idle", {31'd0, imem_req}, 32'd0);
    check("t5_valid_idle", {31'd0, instr_valid}, 32'd0);
    check("t5_retired", retired, 32'd7);
    imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    tick(); tick();
    check("t5_stray_req", {31'd0, imem_req}, 32'd0);
    check("t5_stray_valid", {31'd0, instr_valid}, 32'd0);
    check("t5_stray_instr", instr, 32'h8C00_0000);
    check("t5_stray_retired", retired, 32'd7);
    imem_ack = 1'b0; halt = 1'b0; instr_ready = 1'b0;
    tick();
    check("t5_resume_req", {31'd0, imem_req}, 32'd1);
    check("t5_resume_addr", imem_addr, 32'h0004_0004);

    // async reset mid-FETCH
    rst_n = 1'b0;
    #1;
    check("t6_async_req", {31'd0, imem_req}, 32'd0);
    check("t6_async_addr", imem_addr, 32'h0);
    check("t6_async_retired", retired, 32'd0);
    check("t6_async_instr", instr, 32'h0);
    tick();
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    rst_n = 1'b1;
    tick();
    imem_ack = 1'b0;
    check("t6_restart_req", {31'd0, imem_req}, 32'd1);
    check("t6_restart_addr", imem_addr, 32'h0);
    check("t6_restart_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    check("t6_stale_ignored", {31'd0, instr_valid}, 32'd0);
    check("t6_stale_instr", instr, 32'h0);

    // wrap corners on the second instance
    b_halt = 1'b0; b_ack = 1'b1; b_rdata = 32'h0000_0020; b_ready = 1'b1;
    tick();
    check("b_first_addr", b_addr, 32'hFFFF_FFFC);
    tick();
    check("b_pcp4_wrap", b_pc_plus4, 32'h0);
    tick();
    check("b_addr_wrap", b_addr, 32'h0);
    check("b_retired1", {30'd0, b_retired}, 32'd1);
    for (int k = 2; k <= 4; k++) begin
      tick(); tick();
      check("b_retired_wrap", {30'd0, b_retired}, 32'(k % 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch and next-PC sequencer. It produces the instruction word whose opcode field (`Op`) drives the main decoder.
- It consumes the decoder's `Jump`/`Branch` outputs, plus the ALU `Zero` flag, to choose the next PC.
- It sits between instruction memory (req/ack handshake) and the decode stage (valid/ready handshake).
- It is the producer end of the opcode/control interface.

Parameters:
- `RESET_PC`, `32'h0000_0000`, PC loaded on reset; must be word aligned.
- `CNT_W`, 32, width of the retired-instruction counter.

Ports:
- `clk`  in  1  system clock; all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `halt`  in  1  stop issuing new fetches while high
- `imem_req`  out  1  fetch request, held until `imem_ack`
- `imem_addr`  out  32  word-aligned fetch address, stable while `imem_req`=1
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle; ignored unless `imem_req`=1
- `imem_rdata`  in  32  instruction word
- `instr_valid`  out  1  `instr`/`Op` valid to decode
- `instr_ready`  in  1  decode accepts the instruction this cycle
- `instr`  out  32  held instruction word
- `Op`  out  6  `instr[31:26]`, combinational from the held register
- `pc_plus4`  out  32  PC of the held instruction + 4
- `Jump`  in  1  decoder output for the held instruction
- `Branch`  in  1  decoder output for the held instruction
- `Zero`  in  1  ALU zero flag for the held instruction
- `retired`  out  `CNT_W`  count of accepted instructions

Behaviour:
- Reset (async, `rst_n`=0):
  - state=IDLE, pc=`RESET_PC`, `instr`=0, `retired`=0.
  - `imem_req`=0, `instr_valid`=0, `imem_addr`=`RESET_PC`.
  - Outputs clear immediately, not at the next edge.
- States:
  - IDLE: `imem_req`=0, `instr_valid`=0. If `halt`=0, go to FETCH next cycle.
  - FETCH: `imem_req`=1, `imem_addr`=pc. On `imem_ack`=1, capture `imem_rdata` into `instr` and go to HOLD. Otherwise stay; `halt` does not abort an outstanding request.
  - HOLD: `instr_valid`=1. On `instr_ready`=1 (accept):
    - pc <= next_pc;
    - `retired` += 1, wrapping modulo 2^`CNT_W`;
    - go to IDLE if `halt`=1, else FETCH.
    - Without accept, stay, with `instr` and pc stable.
- next_pc, evaluated only at accept, from the `Jump`/`Branch`/`Zero` sampled that cycle:
  - `Jump`=1: `{pc_plus4[31:28], instr[25:0], 2'b00}`.
  - else `Branch`&`Zero`: `pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00}`, modulo 2^32.
  - else `pc_plus4`.
  - `Jump` has priority over `Branch`.
- `pc_plus4` = pc+4 modulo 2^32; 0xFFFF_FFFC wraps to 0.
- Latency:
  - Memory acking in the first FETCH cycle gives `instr_valid` the next cycle.
  - Best throughput is one instruction per 2 cycles (FETCH, HOLD).
- `imem_ack` in IDLE or HOLD is ignored, including a stale ack arriving after reset.
- `halt` rising during HOLD: the held instruction is still delivered, then the block parks in IDLE. Deasserting `halt` resumes fetch at the computed pc.
- The control inputs are don't-care outside an accept cycle.

Decomposition:
- Shared package (`cpu_pkg`) holds:
  - the state encoding (IDLE=2'd0, FETCH=2'd1, HOLD=2'd2);
  - opcode constants OP_RTYPE=6'b000000, OP_J=6'b000010, OP_LW=6'b100011, OP_SW=6'b101011, OP_BEQ=6'b000100;
  - `RESET_PC`.
- One combinational sub-module, `next_pc_calc`: inputs pc_plus4, instr, Jump, Branch, Zero; output next_pc. It is reused by verification as the reference model.

Test Plan:
- Reset then `halt`=0, memory acks same cycle with `32'h0000_0020` (R-type) → `imem_addr`=0x0, `instr_valid` next cycle, `Op`=0. Accept with `Jump`=`Branch`=0 → next fetch at 0x4, `retired`=1.
- Held instr `32'h0800_0010` (j) at pc 0x4, `Jump`=1 on accept → next `imem_addr`=0x0000_0040.
- Beq `32'h1000_FFFF` at pc 0x40 → `Branch`=1,`Zero`=1 gives next addr 0x40; `Zero`=0 gives 0x44. `Jump`=1 with `Branch`=1 → jump target wins.
- Memory delays ack 3 cycles; decode holds `instr_ready`=0 for 4 cycles → `imem_addr` stable throughout, `instr` unchanged, `retired` increments exactly once.
- `halt`=1 during HOLD → instruction accepted, state IDLE, `imem_req`=0. Stray `imem_ack` pulse ignored. Release `halt` → fetch resumes at the correct next pc.
- `rst_n` low mid-FETCH → `imem_req` drops asynchronously. After release, fetch restarts at `RESET_PC`. `retired` at 0xFFFF_FFFF plus one accept → 0. pc 0xFFFF_FFFC sequential → 0x0.
